// File: rtl/axis_frame_mux_pkg.sv
// rtl/axis_frame_mux_pkg.sv - shared constants for the frame-aware stream mux
package axis_frame_mux_pkg;

  localparam logic FRAME_IDLE = 1'b0;
  localparam logic FRAME_BUSY = 1'b1;

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - registered output stage with one-entry skid buffer
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             ready_int,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] temp_data;
  logic             temp_valid;
  logic             ready_int_early;
  logic             out_valid_next;
  logic             temp_valid_next;
  logic             load_out_in;
  logic             load_temp_in;
  logic             load_out_temp;

  // Upstream ready is registered, so a beat may already be in flight when
  // the sink stalls; the temp register catches it.
  assign ready_int_early = out_ready || (!temp_valid && (!out_valid || !in_valid));

  always_comb begin
    out_valid_next  = out_valid;
    temp_valid_next = temp_valid;
    load_out_in     = 1'b0;
    load_temp_in    = 1'b0;
    load_out_temp   = 1'b0;
    if (ready_int) begin
      if (out_ready || !out_valid) begin
        out_valid_next = in_valid;
        load_out_in    = 1'b1;
      end else begin
        temp_valid_next = in_valid;
        load_temp_in    = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_next  = temp_valid;
      temp_valid_next = 1'b0;
      load_out_temp   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      temp_valid <= 1'b0;
      ready_int  <= 1'b0;
      out_data   <= '0;
      temp_data  <= '0;
    end else begin
      out_valid  <= out_valid_next;
      temp_valid <= temp_valid_next;
      ready_int  <= ready_int_early;
      if (load_out_in) begin
        out_data <= in_data;
      end else if (load_out_temp) begin
        out_data <= temp_data;
      end
      if (load_temp_in) begin
        temp_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_frame_mux.sv
// rtl/axis_frame_mux.sv - merges S_COUNT streams onto one output, one frame at a time
module axis_frame_mux
  import axis_frame_mux_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_ENABLE   = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int CL_S_COUNT  = (S_COUNT > 2) ? $clog2(S_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]      s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  input  logic                             enable,
  input  logic [CL_S_COUNT-1:0]            select
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [CL_S_COUNT:0] S_COUNT_W = (CL_S_COUNT + 1)'(S_COUNT);

  logic                     frame_reg;
  logic [CL_S_COUNT-1:0]    select_reg;
  logic                     ready_int;
  logic                     input_valid_int;
  logic                     select_ok;
  int unsigned              sel_i;
  logic [KEEP_WIDTH-1:0]    keep_sel;
  logic [ID_WIDTH-1:0]      id_sel;
  logic [DEST_WIDTH-1:0]    dest_sel;
  logic [USER_WIDTH-1:0]    user_sel;
  logic [PAYLOAD_WIDTH-1:0] payload_in;
  logic [PAYLOAD_WIDTH-1:0] payload_out;

  assign select_ok       = ({1'b0, select} < S_COUNT_W);
  assign sel_i           = 32'(select_reg);
  assign input_valid_int = frame_reg && ready_int && s_axis_tvalid[select_reg];

  always_comb begin
    s_axis_tready = '0;
    if (frame_reg && ready_int) begin
      s_axis_tready[select_reg] = 1'b1;
    end
  end

  // Frame ownership: a port is latched only from IDLE, so the tlast cycle
  // can never capture the next select and a one-cycle gap always follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg  <= FRAME_IDLE;
      select_reg <= '0;
    end else if (frame_reg == FRAME_IDLE) begin
      if (enable && select_ok && s_axis_tvalid[select]) begin
        frame_reg  <= FRAME_BUSY;
        select_reg <= select;
      end
    end else if (input_valid_int && s_axis_tlast[select_reg]) begin
      frame_reg <= FRAME_IDLE;
    end
  end

  assign keep_sel = (KEEP_ENABLE != 0) ? s_axis_tkeep[sel_i*KEEP_WIDTH +: KEEP_WIDTH] : '1;
  assign id_sel   = (ID_ENABLE   != 0) ? s_axis_tid[sel_i*ID_WIDTH +: ID_WIDTH]       : '0;
  assign dest_sel = (DEST_ENABLE != 0) ? s_axis_tdest[sel_i*DEST_WIDTH +: DEST_WIDTH] : '0;
  assign user_sel = (USER_ENABLE != 0) ? s_axis_tuser[sel_i*USER_WIDTH +: USER_WIDTH] : '0;

  assign payload_in = {s_axis_tdata[sel_i*DATA_WIDTH +: DATA_WIDTH], keep_sel,
                       s_axis_tlast[select_reg], id_sel, dest_sel, user_sel};

  axis_skid_reg #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (payload_in),
    .in_valid  (input_valid_int),
    .ready_int (ready_int),
    .out_data  (payload_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = payload_out;

endmodule
